sram_word_responder: RTL and testbench

- Responder side of the LSU-to-SRAM request interface. Accepts 32-bit word requests with a byte mask from the LSU data-memory window.
- Serves each request as two 16-bit accesses to the external IS61WV25616 asynchronous SRAM, low half first, then high half.
- Signals completion with a one-cycle o_ack. The LSU holds its pipeline stall until it sees o_ack.

---
 rtl/sram_word_responder.sv | 163 ++++++++++++++++
 tb/tb_sram_word_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_responder.sv
// LSU word requests served as two 16-bit accesses to an IS61WV25616
// asynchronous SRAM, low half first, with a one-cycle completion ack.
module sram_word_responder #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned AW          = 19
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic [3:0]    i_bmask,
   input  logic          i_wren,
   input  logic          i_rden,
   output logic [31:0]   o_rdata,
   output logic          o_ack,
   output logic [17:0]   SRAM_ADDR,
   inout  wire  [15:0]   SRAM_DQ,
   output logic          SRAM_CE_N,
   output logic          SRAM_WE_N,
   output logic          SRAM_OE_N,
   output logic          SRAM_LB_N,
   output logic          SRAM_UB_N
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LO_ACC,
      LO_GAP,
      HI_ACC,
      HI_GAP,
      ACK
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-3:0] waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    bmask_q, bmask_d;
   logic          wr_q, wr_d;

   logic [31:0]   rdata_q;
   logic          ack_q;
   logic [17:0]   saddr_q;
   logic          ce_n_q, we_n_q, oe_n_q;
   logic          lb_n_q, ub_n_q;
   logic          dq_oe_q;
   logic [15:0]   dq_out_q;

   logic          req, take;
   logic          lo_skip, hi_skip;
   logic          lo_d, hi_d, act_d, acc_d;
   logic [1:0]    lane_d;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^i_addr[1:0];

   always_comb begin
      req     = i_wren | i_rden;
      take    = (state_q == IDLE) && req;
      waddr_d = take ? i_addr[AW-1:2] : waddr_q;
      wdata_d = take ? i_wdata : wdata_q;
      bmask_d = take ? i_bmask : bmask_q;
      wr_d    = take ? i_wren : wr_q;
      lo_skip = wr_d && (bmask_d[1:0] == 2'b00);
      hi_skip = wr_d && (bmask_d[3:2] == 2'b00);

      state_d = state_q;
      cnt_d   = CNT_LOAD;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (!lo_skip)
                  state_d = LO_ACC;
               else if (!hi_skip)
                  state_d = HI_ACC;
               else
                  state_d = ACK;
            end
         end
         LO_ACC: begin
            if (cnt_q == 4'd0)
               state_d = LO_GAP;
            else
               cnt_d = cnt_q - 4'd1;
         end
         LO_GAP: state_d = hi_skip ? ACK : HI_ACC;
         HI_ACC: begin
            if (cnt_q == 4'd0)
               state_d = HI_GAP;
            else
               cnt_d = cnt_q - 4'd1;
         end
         HI_GAP:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      lo_d   = (state_d == LO_ACC) || (state_d == LO_GAP);
      hi_d   = (state_d == HI_ACC) || (state_d == HI_GAP);
      act_d  = lo_d || hi_d;
      acc_d  = (state_d == LO_ACC) || (state_d == HI_ACC);
      lane_d = lo_d ? bmask_d[1:0] : bmask_d[3:2];
   end

   // Pins are decoded from the next state so they change on the same
   // edge as the state itself; WE_N rises one cycle before data drops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_LOAD;
         waddr_q  <= '0;
         wdata_q  <= '0;
         bmask_q  <= '0;
         wr_q     <= 1'b0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         saddr_q  <= '0;
         ce_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         lb_n_q   <= 1'b1;
         ub_n_q   <= 1'b1;
         dq_oe_q  <= 1'b0;
         dq_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         bmask_q  <= bmask_d;
         wr_q     <= wr_d;
         ack_q    <= (state_d == ACK);
         if (act_d)
            saddr_q <= 18'({waddr_d, hi_d});
         ce_n_q   <= ~act_d;
         oe_n_q   <= ~(act_d && !wr_d);
         we_n_q   <= ~(acc_d && wr_d);
         lb_n_q   <= act_d ? ~(wr_d ? lane_d[0] : 1'b1) : 1'b1;
         ub_n_q   <= act_d ? ~(wr_d ? lane_d[1] : 1'b1) : 1'b1;
         dq_oe_q  <= act_d && wr_d;
         dq_out_q <= lo_d ? wdata_d[15:0] : wdata_d[31:16];
         if (!wr_q && (cnt_q == 4'd0)) begin
            if (state_q == LO_ACC)
               rdata_q[15:0] <= SRAM_DQ;
            if (state_q == HI_ACC)
               rdata_q[31:16] <= SRAM_DQ;
         end
      end
   end

   assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
   assign o_rdata   = rdata_q;
   assign o_ack     = ack_q;
   assign SRAM_ADDR = saddr_q;
   assign SRAM_CE_N = ce_n_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_OE_N = oe_n_q;
   assign SRAM_LB_N = lb_n_q;
   assign SRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_sram_word_responder.sv
// Bench for sram_word_responder: WAIT_CYCLES=1 and 3 instances side by
// side, each on its own SRAM model, checked against a word-level model.
module tb_sram_word_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [18:0] addr;
   logic [31:0] wdata;
   logic [3:0]  bmask;
   logic        wren, rden;
   logic        probe;

   logic [31:0] rdata [2];
   logic [17:0] saddr [2];
   logic        ack [2];
   logic        ce_n [2];
   logic        we_n [2];
   logic        oe_n [2];
   logic        lb_n [2];
   logic        ub_n [2];
   logic [15:0] dqv [2];

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [8];
   bit          vld [8];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int W = (g == 0) ? 1 : 3;
      wire  [15:0] dq;
      logic [15:0] mem [0:255];
      logic        mdrv;

      sram_word_responder #(.WAIT_CYCLES(W), .AW(19)) u_dut (
         .i_clk     (clk),
         .i_rst_n   (rst_n),
         .i_addr    (addr),
         .i_wdata   (wdata),
         .i_bmask   (bmask),
         .i_wren    (wren),
         .i_rden    (rden),
         .o_rdata   (rdata[g]),
         .o_ack     (ack[g]),
         .SRAM_ADDR (saddr[g]),
         .SRAM_DQ   (dq),
         .SRAM_CE_N (ce_n[g]),
         .SRAM_WE_N (we_n[g]),
         .SRAM_OE_N (oe_n[g]),
         .SRAM_LB_N (lb_n[g]),
         .SRAM_UB_N (ub_n[g])
      );

      assign mdrv = !ce_n[g] && !oe_n[g] && we_n[g];
      assign dq = mdrv ? mem[saddr[g][7:0]] : 16'bz;
      assign dq = probe ? 16'h0000 : 16'bz;
      assign dqv[g] = dq;

      always @(negedge clk) begin
         if (!ce_n[g] && !we_n[g]) begin
            if (!lb_n[g]) mem[saddr[g][7:0]][7:0] <= dq[7:0];
            if (!ub_n[g]) mem[saddr[g][7:0]][15:8] <= dq[15:8];
         end
      end
   end

   function automatic int wc(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request, accepted by both instances on the same edge; the pins
   // are watched for the next 11 cycles and summarised.
   task automatic xact(input bit wr, input bit rd, input int k,
                       input logic [31:0] d, input logic [3:0] m);
      int acc;
      int lat [2];
      int na [2];
      int nce [2];
      int nwe [2];
      int noe [2];
      int bad [2];
      logic [15:0] half;
      logic [1:0]  lane;
      acc = wr ? (int'(m[1:0] != 2'b00) + int'(m[3:2] != 2'b00)) : 2;
      for (int g = 0; g < 2; g++) begin
         lat[g] = -1; na[g] = 0; nce[g] = 0;
         nwe[g] = 0; noe[g] = 0; bad[g] = 0;
      end
      wren = wr; rden = rd;
      addr = {k[16:0], 2'($urandom)};
      wdata = d; bmask = m;
      @(posedge clk);
      for (int e = 0; e <= 10; e++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (ack[g]) begin
               na[g]++;
               if (lat[g] < 0) lat[g] = e;
            end
            if (!ce_n[g]) begin
               nce[g]++;
               half = saddr[g][0] ? d[31:16] : d[15:0];
               lane = saddr[g][0] ? m[3:2] : m[1:0];
               if (saddr[g][17:1] != 17'(k)) bad[g]++;
               if (!oe_n[g] && (wr || !we_n[g] || lb_n[g] || ub_n[g]))
                  bad[g]++;
               if (!we_n[g] && {ub_n[g], lb_n[g]} != ~lane) bad[g]++;
               if (!we_n[g] && dqv[g] !== half) bad[g]++;
            end
            if (!we_n[g]) nwe[g]++;
            if (!oe_n[g]) noe[g]++;
         end
         if (e == 0) begin
            wren = 1'b0; rden = 1'b0;
            addr = 19'($urandom); wdata = $urandom; bmask = 4'($urandom);
         end
      end
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
      end else begin
         last_rd = ref_mem[k];
      end
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("ack_latency%0d", g), lat[g], acc * (wc(g) + 1));
         chk($sformatf("ack_pulses%0d", g), na[g], 1);
         chk($sformatf("ce_cycles%0d", g), nce[g], acc * (wc(g) + 1));
         chk($sformatf("we_cycles%0d", g), nwe[g], wr ? acc * wc(g) : 0);
         chk($sformatf("oe_cycles%0d", g), noe[g], wr ? 0 : 2 * (wc(g) + 1));
         chk($sformatf("pin_errors%0d", g), bad[g], 0);
         chk($sformatf("rdata%0d", g), rdata[g], last_rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int hold_e;
   int rk;
   bit rop;

   initial begin
      rst_n = 1'b0; probe = 1'b1;
      wren = 1'b0; rden = 1'b0;
      addr = '0; wdata = '0; bmask = '0;
      last_rd = '0;
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = '0; vld[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst_ack%0d", g), ack[g], 0);
         chk($sformatf("rst_rdata%0d", g), rdata[g], 0);
         chk($sformatf("rst_saddr%0d", g), saddr[g], 0);
         chk($sformatf("rst_strobes%0d", g),
             {ce_n[g], we_n[g], oe_n[g], lb_n[g], ub_n[g]}, 5'h1f);
         chk($sformatf("rst_bus_free%0d", g), dqv[g], 16'h0000);
      end
      rst_n = 1'b1; probe = 1'b0;
      @(negedge clk);

      xact(1, 0, 4, 32'hDEADBEEF, 4'hF); vld[4] = 1'b1;
      xact(0, 1, 4, $urandom, 4'($urandom));
      xact(1, 0, 4, 32'h000000AA, 4'h1);
      xact(0, 1, 4, $urandom, 4'($urandom));
      chk("byte_write_word", last_rd, 32'hDEADBEAA);
      xact(1, 0, 4, 32'h12340000, 4'hC);
      xact(0, 1, 4, $urandom, 4'($urandom));
      chk("hi_write_word", last_rd, 32'h1234BEAA);
      xact(1, 0, 4, 32'hFFFFFFFF, 4'h0);
      xact(0, 1, 4, $urandom, 4'($urandom));
      chk("empty_mask_word", last_rd, 32'h1234BEAA);
      xact(1, 1, 4, 32'hCAFEF00D, 4'hF);
      xact(0, 1, 4, $urandom, 4'($urandom));
      chk("priority_word", last_rd, 32'hCAFEF00D);

      // Request held through ACK on the WAIT_CYCLES=1 instance.
      hold_e = -1;
      wren = 1'b1; rden = 1'b0;
      addr = {17'd5, 2'b00}; wdata = 32'h0BADC0DE; bmask = 4'hF;
      @(posedge clk);
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         if (ack[0]) begin
            hold_e = e;
            break;
         end
      end
      chk("hold_ack_latency", hold_e, 4);
      @(negedge clk);
      chk("hold_idle_ce", ce_n[0], 1);
      @(negedge clk);
      chk("hold_reaccept_ce", ce_n[0], 0);
      wren = 1'b0;
      repeat (16) @(negedge clk);
      ref_mem[5] = 32'h0BADC0DE; vld[5] = 1'b1;
      xact(0, 1, 5, $urandom, 4'($urandom));

      for (int i = 0; i < 8; i++) begin
         xact(1, 0, i, $urandom, 4'hF);
         vld[i] = 1'b1;
      end
      repeat (40) begin
         rk = $urandom_range(0, 7);
         rop = 1'($urandom_range(0, 1));
         if (rop)
            xact(1, 1'($urandom_range(0, 1)), rk, $urandom, 4'($urandom));
         else
            xact(0, 1, rk, $urandom, 4'($urandom));
      end

      // Reset dropped while the WAIT_CYCLES=1 instance sits in HI_ACC.
      wren = 1'b1; rden = 1'b0;
      addr = {17'd6, 2'b00}; wdata = 32'h5A5AA5A5; bmask = 4'hF;
      @(posedge clk);
      @(negedge clk);
      wren = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_hi_acc", {saddr[0][0], we_n[0], ce_n[0]}, 3'b100);
      rst_n = 1'b0; probe = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("abort_strobes%0d", g),
             {ce_n[g], we_n[g], oe_n[g], lb_n[g], ub_n[g]}, 5'h1f);
         chk($sformatf("abort_bus_free%0d", g), dqv[g], 16'h0000);
         chk($sformatf("abort_ack%0d", g), ack[g], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; probe = 1'b0;
      repeat (3) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("post_rst_ack%0d", g), ack[g], 0);
            chk($sformatf("post_rst_ce%0d", g), ce_n[g], 1);
         end
      end
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("post_rst_rdata%0d", g), rdata[g], 0);
         chk($sformatf("post_rst_saddr%0d", g), saddr[g], 0);
      end
      vld[6] = 1'b0;
      last_rd = '0;
      xact(0, 1, 4, $urandom, 4'($urandom));
      xact(0, 1, 7, $urandom, 4'($urandom));
      xact(1, 0, 6, 32'h600DF00D, 4'hF); vld[6] = 1'b1;
      xact(0, 1, 6, $urandom, 4'($urandom));
      chk("rewrite_word", last_rd, 32'h600DF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
